// File: rtl/io_sequencer.sv
// Sequences the CPU's IN/OUT instructions: stalls the core, drives the display mux,
// and waits for a debounced confirm press before completing the instruction.
module io_sequencer #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter logic [31:0] OUT_HOLD_CYCLES = 32'd0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        io_req,
   input  logic [1:0]  io_op,
   input  logic        confirm_btn,
   input  logic [31:0] switches,
   output logic [1:0]  outputControl,
   output logic [31:0] in_data,
   output logic        reg_we,
   output logic        done,
   output logic        stall,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_IN_WAIT  = 3'd1,
      S_OUT_SHOW = 3'd2,
      S_RELEASE  = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t      cur;
   logic [1:0]  sync_q;
   logic        db_level;
   logic [15:0] db_cnt;
   logic [31:0] hold_cnt;
   logic        is_in;
   logic        db_toggle;
   logic        db_next;
   logic        press;
   logic        hold_ok;
   logic        req_in;
   logic        req_out;

   assign state = cur;

   // Handshake: io_req is a level held by the control unit; it is sampled only in IDLE,
   // the core is frozen by stall until the single-cycle done pulse, and stall is low in DONE.
   assign req_in  = io_req && (io_op == 2'd1);
   assign req_out = io_req && (io_op == 2'd2);

   assign db_toggle = (sync_q[1] != db_level) &&
                      (({1'b0, db_cnt} + 17'd1) >= {1'b0, DEBOUNCE_CYCLES});
   assign db_next   = db_toggle ? ~db_level : db_level;
   assign press     = db_toggle && !db_level;
   assign hold_ok   = (hold_cnt >= OUT_HOLD_CYCLES);

   assign stall = (cur == S_IN_WAIT) || (cur == S_OUT_SHOW) || (cur == S_RELEASE) ||
                  ((cur == S_IDLE) && (req_in || req_out));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], confirm_btn};
      end
   end

   // Any sample agreeing with the debounced level restarts the stability count.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         db_level <= 1'b0;
         db_cnt   <= 16'd0;
      end else if (sync_q[1] == db_level) begin
         db_cnt <= 16'd0;
      end else if (db_toggle) begin
         db_level <= ~db_level;
         db_cnt   <= 16'd0;
      end else begin
         db_cnt <= db_cnt + 16'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cur           <= S_IDLE;
         outputControl <= 2'd0;
         in_data       <= 32'd0;
         reg_we        <= 1'b0;
         done          <= 1'b0;
         hold_cnt      <= 32'd0;
         is_in         <= 1'b0;
      end else begin
         case (cur)
            S_IDLE: begin
               if (req_in) begin
                  cur           <= S_IN_WAIT;
                  outputControl <= 2'd1;
                  is_in         <= 1'b1;
               end else if (req_out) begin
                  cur           <= S_OUT_SHOW;
                  outputControl <= 2'd2;
                  is_in         <= 1'b0;
                  hold_cnt      <= 32'd0;
               end
            end
            S_IN_WAIT: begin
               if (press) begin
                  in_data <= switches;
                  cur     <= S_RELEASE;
               end
            end
            S_OUT_SHOW: begin
               if (!hold_ok) begin
                  hold_cnt <= hold_cnt + 32'd1;
               end
               if (press && hold_ok) begin
                  cur <= S_RELEASE;
               end
            end
            // Waiting for the button to be let go keeps one press from serving two instructions.
            S_RELEASE: begin
               if (!db_next) begin
                  cur           <= S_DONE;
                  done          <= 1'b1;
                  reg_we        <= is_in;
                  outputControl <= 2'd0;
               end
            end
            S_DONE: begin
               cur    <= S_IDLE;
               done   <= 1'b0;
               reg_we <= 1'b0;
            end
            default: begin
               cur           <= S_IDLE;
               outputControl <= 2'd0;
               done          <= 1'b0;
               reg_we        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_io_sequencer.sv
// Directed bench for io_sequencer with DEBOUNCE_CYCLES=4 and OUT_HOLD_CYCLES=8.
module tb_io_sequencer;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_IN_WAIT  = 3'd1;
   localparam logic [2:0] ST_OUT_SHOW = 3'd2;
   localparam logic [2:0] ST_RELEASE  = 3'd3;
   localparam logic [2:0] ST_DONE     = 3'd4;

   logic        clock;
   logic        reset;
   logic        io_req;
   logic [1:0]  io_op;
   logic        confirm_btn;
   logic [31:0] switches;
   logic [1:0]  outputControl;
   logic [31:0] in_data;
   logic        reg_we;
   logic        done;
   logic        stall;
   logic [2:0]  state;

   int errors;
   int checks;
   int done_cnt;
   int we_cnt;

   typedef struct {
      logic       req;
      logic [1:0] op;
      logic       exp_stall;
      logic [2:0] exp_state;
      logic [1:0] exp_oc;
   } vec_t;

   vec_t vecs[6];

   io_sequencer #(
      .DEBOUNCE_CYCLES(16'd4),
      .OUT_HOLD_CYCLES(32'd8)
   ) dut (
      .clock(clock),
      .reset(reset),
      .io_req(io_req),
      .io_op(io_op),
      .confirm_btn(confirm_btn),
      .switches(switches),
      .outputControl(outputControl),
      .in_data(in_data),
      .reg_we(reg_we),
      .done(done),
      .stall(stall),
      .state(state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (!reset) begin
         if (done) done_cnt++;
         if (reg_we) we_cnt++;
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   initial begin
      errors      = 0;
      checks      = 0;
      done_cnt    = 0;
      we_cnt      = 0;
      reset       = 1'b1;
      io_req      = 1'b0;
      io_op       = 2'd0;
      confirm_btn = 1'b0;
      switches    = 32'd0;

      vecs[0] = '{1'b1, 2'd0, 1'b0, ST_IDLE,     2'd0};
      vecs[1] = '{1'b1, 2'd3, 1'b0, ST_IDLE,     2'd0};
      vecs[2] = '{1'b0, 2'd1, 1'b0, ST_IDLE,     2'd0};
      vecs[3] = '{1'b0, 2'd2, 1'b0, ST_IDLE,     2'd0};
      vecs[4] = '{1'b1, 2'd1, 1'b1, ST_IN_WAIT,  2'd1};
      vecs[5] = '{1'b1, 2'd2, 1'b1, ST_OUT_SHOW, 2'd2};

      // Reset state
      step();
      chk("rst_state", 32'(state), 32'(ST_IDLE));
      chk("rst_oc", 32'(outputControl), 32'd0);
      chk("rst_in_data", in_data, 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_reg_we", 32'(reg_we), 32'd0);

      // Request decode from IDLE
      for (int i = 0; i < 6; i++) begin
         reset_dut();
         io_req = vecs[i].req;
         io_op  = vecs[i].op;
         #1;
         chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
         step();
         chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
         chk($sformatf("vec%0d_oc", i), 32'(outputControl), 32'(vecs[i].exp_oc));
         io_req = 1'b0;
         io_op  = 2'd0;
      end
      reset_dut();

      // IN happy path
      switches = 32'hDEADBEEF;
      io_req   = 1'b1;
      io_op    = 2'd1;
      #1;
      chk("in_req_stall", 32'(stall), 32'd1);
      chk("in_req_state", 32'(state), 32'(ST_IDLE));
      step();
      chk("in_state", 32'(state), 32'(ST_IN_WAIT));
      chk("in_oc", 32'(outputControl), 32'd1);
      chk("in_stall", 32'(stall), 32'd1);
      io_req      = 1'b0;
      io_op       = 2'd0;
      confirm_btn = 1'b1;
      repeat (5) step();
      chk("in_prepress_state", 32'(state), 32'(ST_IN_WAIT));
      chk("in_prepress_data", in_data, 32'd0);
      step();
      chk("in_press_state", 32'(state), 32'(ST_RELEASE));
      chk("in_capture", in_data, 32'hDEADBEEF);
      chk("in_release_oc", 32'(outputControl), 32'd1);
      switches = 32'h12345678;
      repeat (4) step();
      confirm_btn = 1'b0;
      repeat (5) step();
      chk("in_hold_release", 32'(state), 32'(ST_RELEASE));
      chk("in_early_done", 32'(done), 32'd0);
      step();
      chk("in_done_state", 32'(state), 32'(ST_DONE));
      chk("in_done", 32'(done), 32'd1);
      chk("in_reg_we", 32'(reg_we), 32'd1);
      chk("in_done_stall", 32'(stall), 32'd0);
      chk("in_done_oc", 32'(outputControl), 32'd0);
      step();
      chk("in_back_idle", 32'(state), 32'(ST_IDLE));
      chk("in_done_clear", 32'(done), 32'd0);
      chk("in_data_hold", in_data, 32'hDEADBEEF);
      chk("in_done_pulses", 32'(done_cnt), 32'd1);

      // Bounce rejection during IN_WAIT
      switches = 32'h0BADF00D;
      io_req   = 1'b1;
      io_op    = 2'd1;
      step();
      io_req = 1'b0;
      chk("bnc_state", 32'(state), 32'(ST_IN_WAIT));
      for (int i = 0; i < 20; i++) begin
         confirm_btn = (((i / 2) % 2) == 0);
         step();
      end
      confirm_btn = 1'b0;
      repeat (2) step();
      chk("bnc_still_wait", 32'(state), 32'(ST_IN_WAIT));
      chk("bnc_data_kept", in_data, 32'hDEADBEEF);
      confirm_btn = 1'b1;
      repeat (6) step();
      chk("bnc_press_state", 32'(state), 32'(ST_RELEASE));
      chk("bnc_capture", in_data, 32'h0BADF00D);
      confirm_btn = 1'b0;
      repeat (6) step();
      chk("bnc_done_state", 32'(state), 32'(ST_DONE));
      chk("bnc_reg_we", 32'(reg_we), 32'd1);
      step();

      // OUT with minimum hold: press debounced at hold count 3 is ignored
      confirm_btn = 1'b1;
      step();
      io_req = 1'b1;
      io_op  = 2'd2;
      #1;
      chk("out_req_stall", 32'(stall), 32'd1);
      step();
      io_req = 1'b0;
      io_op  = 2'd0;
      chk("out_state", 32'(state), 32'(ST_OUT_SHOW));
      chk("out_oc", 32'(outputControl), 32'd2);
      repeat (4) step();
      chk("out_early_ignored", 32'(state), 32'(ST_OUT_SHOW));
      chk("out_early_oc", 32'(outputControl), 32'd2);
      confirm_btn = 1'b0;
      repeat (6) step();
      chk("out_no_queue", 32'(state), 32'(ST_OUT_SHOW));
      confirm_btn = 1'b1;
      repeat (5) step();
      chk("out_prepress", 32'(state), 32'(ST_OUT_SHOW));
      step();
      chk("out_accept", 32'(state), 32'(ST_RELEASE));
      chk("out_release_oc", 32'(outputControl), 32'd2);
      confirm_btn = 1'b0;
      repeat (5) step();
      chk("out_hold_release", 32'(state), 32'(ST_RELEASE));
      step();
      chk("out_done_state", 32'(state), 32'(ST_DONE));
      chk("out_done", 32'(done), 32'd1);
      chk("out_reg_we", 32'(reg_we), 32'd0);
      chk("out_done_oc", 32'(outputControl), 32'd0);
      step();
      chk("out_back_idle", 32'(state), 32'(ST_IDLE));
      chk("out_in_data_kept", in_data, 32'h0BADF00D);

      // Back-to-back IN: request kept high through DONE, then button held into the next op
      switches = 32'h11111111;
      io_req   = 1'b1;
      io_op    = 2'd1;
      step();
      chk("b2b_a_state", 32'(state), 32'(ST_IN_WAIT));
      confirm_btn = 1'b1;
      repeat (6) step();
      chk("b2b_a_capture", in_data, 32'h11111111);
      confirm_btn = 1'b0;
      repeat (6) step();
      chk("b2b_a_done_state", 32'(state), 32'(ST_DONE));
      chk("b2b_a_done_stall", 32'(stall), 32'd0);
      step();
      chk("b2b_a_no_accept_in_done", 32'(state), 32'(ST_IDLE));
      chk("b2b_idle_req_stall", 32'(stall), 32'd1);
      io_req      = 1'b0;
      confirm_btn = 1'b1;
      repeat (8) step();
      switches = 32'h22222222;
      io_req   = 1'b1;
      step();
      io_req = 1'b0;
      chk("b2b_b_state", 32'(state), 32'(ST_IN_WAIT));
      repeat (10) step();
      chk("b2b_held_no_press", 32'(state), 32'(ST_IN_WAIT));
      chk("b2b_held_data", in_data, 32'h11111111);
      confirm_btn = 1'b0;
      repeat (6) step();
      chk("b2b_after_release", 32'(state), 32'(ST_IN_WAIT));
      confirm_btn = 1'b1;
      repeat (6) step();
      chk("b2b_fresh_press", 32'(state), 32'(ST_RELEASE));
      chk("b2b_b_capture", in_data, 32'h22222222);
      confirm_btn = 1'b0;
      repeat (6) step();
      chk("b2b_b_done", 32'(done), 32'd1);
      chk("b2b_b_reg_we", 32'(reg_we), 32'd1);
      step();

      // Asynchronous reset in OUT_SHOW, away from a clock edge
      io_req = 1'b1;
      io_op  = 2'd2;
      step();
      io_req = 1'b0;
      io_op  = 2'd0;
      chk("rmid_state", 32'(state), 32'(ST_OUT_SHOW));
      #3;
      reset = 1'b1;
      #1;
      chk("rmid_async_state", 32'(state), 32'(ST_IDLE));
      chk("rmid_async_oc", 32'(outputControl), 32'd0);
      chk("rmid_async_stall", 32'(stall), 32'd0);
      chk("rmid_async_in_data", in_data, 32'd0);
      step();
      reset = 1'b0;
      repeat (3) step();
      chk("rmid_idle", 32'(state), 32'(ST_IDLE));
      chk("rmid_no_done", 32'(done), 32'd0);

      chk("total_done_pulses", 32'(done_cnt), 32'd5);
      chk("total_reg_we_pulses", 32'(we_cnt), 32'd4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
